// File: rtl/spu_pkg.sv
// Shared types and widths for the SPU writeback stage.
package spu_pkg;

  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned REG_DATA_W = 128;
  localparam int unsigned MAX_LAT    = 7;
  localparam int unsigned LAT_W      = 3;

  typedef logic [0:REG_ADDR_W-1] reg_addr_t;
  typedef logic [0:REG_DATA_W-1] reg_data_t;
  typedef logic [0:LAT_W-1]      lat_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t addr;
    reg_data_t data;
  } wb_slot_t;

endpackage

// File: rtl/wb_delay_line.sv
// One pipe's result delay line: slot[k] drains toward slot[1], issues land at slot[lat].
module wb_delay_line
  import spu_pkg::*;
#(
  parameter int unsigned MAX_LAT = spu_pkg::MAX_LAT
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      issue_valid,
  input  lat_t      issue_lat,
  input  reg_addr_t issue_addr,
  input  reg_data_t issue_data,
  output logic      issue_ready,
  output wb_slot_t  slot_q [1:MAX_LAT]
);

  int unsigned lat_n;
  logic        accept;
  wb_slot_t    ins;

  assign lat_n = 32'(issue_lat);

  // A slot is free for insertion only if nothing would shift into it from above.
  always_comb begin
    issue_ready = 1'b0;
    for (int unsigned k = 2; k < MAX_LAT; k++) begin
      if (lat_n == k) issue_ready = !slot_q[k+1].valid;
    end
    if (lat_n == MAX_LAT) issue_ready = 1'b1;
  end

  assign accept = issue_valid && issue_ready && !flush;
  assign ins    = '{valid: 1'b1, addr: issue_addr, data: issue_data};

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int unsigned k = 1; k <= MAX_LAT; k++) slot_q[k].valid <= 1'b0;
    end else begin
      for (int unsigned k = 1; k < MAX_LAT; k++) begin
        slot_q[k] <= (accept && lat_n == k) ? ins : slot_q[k+1];
      end
      if (accept && lat_n == MAX_LAT) slot_q[MAX_LAT] <= ins;
      else                            slot_q[MAX_LAT].valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spu_writeback.sv
// Even/odd result writeback scheduling, pending-register queries and WAW detection.
module spu_writeback
  import spu_pkg::*;
#(
  parameter int unsigned NUM_QRY = 6,
  parameter int unsigned MAX_LAT = spu_pkg::MAX_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  ev_issue_valid,
  input  logic [0:LAT_W-1]      ev_issue_lat,
  input  logic [0:REG_ADDR_W-1] ev_issue_addr,
  input  logic [0:REG_DATA_W-1] ev_issue_data,
  output logic                  ev_issue_ready,
  input  logic                  od_issue_valid,
  input  logic [0:LAT_W-1]      od_issue_lat,
  input  logic [0:REG_ADDR_W-1] od_issue_addr,
  input  logic [0:REG_DATA_W-1] od_issue_data,
  output logic                  od_issue_ready,
  output logic                  reg_write_en_1,
  output logic [0:REG_ADDR_W-1] reg_write_addr_1,
  output logic [0:REG_DATA_W-1] reg_write_data_1,
  output logic                  reg_write_en_2,
  output logic [0:REG_ADDR_W-1] reg_write_addr_2,
  output logic [0:REG_DATA_W-1] reg_write_data_2,
  input  logic [0:REG_ADDR_W-1] qry_addr_1,
  input  logic [0:REG_ADDR_W-1] qry_addr_2,
  input  logic [0:REG_ADDR_W-1] qry_addr_3,
  input  logic [0:REG_ADDR_W-1] qry_addr_4,
  input  logic [0:REG_ADDR_W-1] qry_addr_5,
  input  logic [0:REG_ADDR_W-1] qry_addr_6,
  output logic                  qry_pend_1,
  output logic                  qry_pend_2,
  output logic                  qry_pend_3,
  output logic                  qry_pend_4,
  output logic                  qry_pend_5,
  output logic                  qry_pend_6,
  output logic                  waw_conflict
);

  wb_slot_t  ev_slot [1:MAX_LAT];
  wb_slot_t  od_slot [1:MAX_LAT];
  reg_addr_t qry_addr [NUM_QRY];
  logic [0:NUM_QRY-1] pend;

  wb_delay_line #(.MAX_LAT(MAX_LAT)) u_ev (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (ev_issue_valid),
    .issue_lat   (ev_issue_lat),
    .issue_addr  (ev_issue_addr),
    .issue_data  (ev_issue_data),
    .issue_ready (ev_issue_ready),
    .slot_q      (ev_slot)
  );

  wb_delay_line #(.MAX_LAT(MAX_LAT)) u_od (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .issue_valid (od_issue_valid),
    .issue_lat   (od_issue_lat),
    .issue_addr  (od_issue_addr),
    .issue_data  (od_issue_data),
    .issue_ready (od_issue_ready),
    .slot_q      (od_slot)
  );

  // Outputs are gated by rst_n so nothing stale is visible while reset is held.
  assign reg_write_en_1   = ev_slot[1].valid && rst_n;
  assign reg_write_addr_1 = ev_slot[1].addr;
  assign reg_write_data_1 = ev_slot[1].data;
  assign reg_write_en_2   = od_slot[1].valid && rst_n;
  assign reg_write_addr_2 = od_slot[1].addr;
  assign reg_write_data_2 = od_slot[1].data;

  assign waw_conflict = reg_write_en_1 && reg_write_en_2 &&
                        (reg_write_addr_1 == reg_write_addr_2);

  assign qry_addr[0] = qry_addr_1;
  assign qry_addr[1] = qry_addr_2;
  assign qry_addr[2] = qry_addr_3;
  assign qry_addr[3] = qry_addr_4;
  assign qry_addr[4] = qry_addr_5;
  assign qry_addr[5] = qry_addr_6;

  always_comb begin
    pend = '0;
    for (int unsigned q = 0; q < NUM_QRY; q++) begin
      for (int unsigned k = 1; k <= MAX_LAT; k++) begin
        if (ev_slot[k].valid && ev_slot[k].addr == qry_addr[q]) pend[q] = 1'b1;
        if (od_slot[k].valid && od_slot[k].addr == qry_addr[q]) pend[q] = 1'b1;
      end
    end
    if (!rst_n) pend = '0;
  end

  assign qry_pend_1 = pend[0];
  assign qry_pend_2 = pend[1];
  assign qry_pend_3 = pend[2];
  assign qry_pend_4 = pend[3];
  assign qry_pend_5 = pend[4];
  assign qry_pend_6 = pend[5];

endmodule
